// File: rtl/tm_queue_depth.sv
// tm_queue_depth: per-queue depth tracker answering enq/deq depth requests and admission polls.
// Optional statistics outputs (drop_count, peak_depth) exist when TM_QUEUE_DEPTH_STATS_EN is defined.
`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 4
`endif

module tm_queue_depth_fifo #(
  parameter int W  = 4,
  parameter int AW = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         ovf_o
);
  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wrPtr_q, rdPtr_q;
  logic         full;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign dout_o  = mem_q[rdPtr_q[AW-1:0]];
  assign ovf_o   = push_i && full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push_i && !full) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (pop_i) rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full) mem_q[wrPtr_q[AW-1:0]] <= din_i;
  end
endmodule

module tm_queue_depth #(
  parameter int QID_NBITS  = `FIRST_LVL_QUEUE_ID_NBITS,
  parameter int FIFO_NBITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_req,
  input  logic [QID_NBITS-1:0] enq_qid,
  input  logic                 deq_req,
  input  logic [QID_NBITS-1:0] deq_qid,
  input  logic                 poll_req,
  input  logic [QID_NBITS-1:0] poll_qid,
  output logic                 depth_enq_ack,
  output logic                 depth_enq_to_empty,
  output logic                 depth_deq_ack,
  output logic                 depth_deq_from_emptyp2,
  output logic                 queue_depth_req,
  input  logic                 ll_queue_depth_ack,
  input  logic                 ll_queue_depth_drop,
  input  logic [QID_NBITS:0]   queue_threshold,
  output logic                 poll_ack,
  output logic                 poll_drop,
  output logic [QID_NBITS:0]   poll_depth,
  output logic                 init_done,
  output logic                 err_overflow,
  output logic                 err_underflow,
`ifdef TM_QUEUE_DEPTH_STATS_EN
  output logic [31:0]          drop_count,
  output logic [QID_NBITS:0]   peak_depth,
`endif
  output logic                 err_fifo_ovf
);
  localparam int DW = QID_NBITS + 1;
  localparam logic [DW-1:0] MaxDepth = {1'b1, {QID_NBITS{1'b0}}};

  typedef enum logic {INIT, RUN} state_e;
  typedef enum logic [1:0] {OP_ENQ, OP_DEQ, OP_POLL} op_e;

  state_e               state_q;
  logic [QID_NBITS-1:0] initAddr_q;
  logic                 initDone_q;

  logic                 enqEmpty, deqEmpty, pollEmpty, enqOvf, deqOvf, pollOvf;
  logic [QID_NBITS-1:0] enqHead, deqHead, pollHead;
  logic                 popEnq, popDeq, popPoll, p1Valid;
  op_e                  p1Op;
  logic [QID_NBITS-1:0] p1Qid;

  logic [DW-1:0]        depthMem [2**QID_NBITS];
  logic [DW-1:0]        rdData_q;
  logic                 memWe;
  logic [QID_NBITS-1:0] memWa;
  logic [DW-1:0]        memWd;

  logic                 s2Valid_q;
  op_e                  s2Op_q;
  logic [QID_NBITS-1:0] s2Qid_q;
  logic                 s3Wr_q, wbValid_q;
  logic [QID_NBITS-1:0] s3Qid_q, wbQid_q;
  logic [DW-1:0]        s3Depth_q, wbDepth_q;

  logic                 isEnq, isDeq, isPoll, pollDrop;
  logic [DW-1:0]        oldDepth, newDepth;

  logic                 enqAck_q, toEmpty_q, deqAck_q, fromEmptyp2_q, pollAck_q, pollDrop_q;
  logic [DW-1:0]        pollDepth_q;
  logic                 errOvf_q, errUnf_q, errFifo_q;

  tm_queue_depth_fifo #(.W(QID_NBITS), .AW(FIFO_NBITS)) u_enqFifo (
    .clk_i(clk), .rst_i(rst), .push_i(enq_req), .pop_i(popEnq), .din_i(enq_qid),
    .dout_o(enqHead), .empty_o(enqEmpty), .ovf_o(enqOvf));
  tm_queue_depth_fifo #(.W(QID_NBITS), .AW(FIFO_NBITS)) u_deqFifo (
    .clk_i(clk), .rst_i(rst), .push_i(deq_req), .pop_i(popDeq), .din_i(deq_qid),
    .dout_o(deqHead), .empty_o(deqEmpty), .ovf_o(deqOvf));
  tm_queue_depth_fifo #(.W(QID_NBITS), .AW(FIFO_NBITS)) u_pollFifo (
    .clk_i(clk), .rst_i(rst), .push_i(poll_req), .pop_i(popPoll), .din_i(poll_qid),
    .dout_o(pollHead), .empty_o(pollEmpty), .ovf_o(pollOvf));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      initAddr_q <= '0;
      initDone_q <= 1'b0;
    end else if (state_q == INIT) begin
      initAddr_q <= initAddr_q + QID_NBITS'(1);
      if (&initAddr_q) begin
        state_q    <= RUN;
        initDone_q <= 1'b1;
      end
    end
  end

  // Fixed-priority arbiter: deq > enq > poll, nothing leaves the FIFOs until the RAM is cleared.
  always_comb begin
    popDeq  = 1'b0;
    popEnq  = 1'b0;
    popPoll = 1'b0;
    p1Op    = OP_POLL;
    p1Qid   = pollHead;
    if (state_q == RUN) begin
      if (!deqEmpty) begin
        popDeq = 1'b1;
        p1Op   = OP_DEQ;
        p1Qid  = deqHead;
      end else if (!enqEmpty) begin
        popEnq = 1'b1;
        p1Op   = OP_ENQ;
        p1Qid  = enqHead;
      end else if (!pollEmpty) begin
        popPoll = 1'b1;
      end
    end
  end

  assign p1Valid         = popDeq || popEnq || popPoll;
  assign queue_depth_req = popPoll;

  always_comb begin
    memWe = s3Wr_q;
    memWa = s3Qid_q;
    memWd = s3Depth_q;
    if (state_q == INIT) begin
      memWe = 1'b1;
      memWa = initAddr_q;
      memWd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) depthMem[memWa] <= memWd;
    rdData_q <= depthMem[p1Qid];
  end

  // The RAM read misses the write in P3 and the one retired a cycle earlier; P3 is the younger.
  assign oldDepth = (s3Wr_q && s3Qid_q == s2Qid_q)       ? s3Depth_q :
                    (wbValid_q && wbQid_q == s2Qid_q)    ? wbDepth_q : rdData_q;

  assign isEnq  = s2Valid_q && (s2Op_q == OP_ENQ);
  assign isDeq  = s2Valid_q && (s2Op_q == OP_DEQ);
  assign isPoll = s2Valid_q && (s2Op_q == OP_POLL);

  // A poll that gets no threshold answer is rejected rather than admitted blindly.
  assign pollDrop = isPoll && (ll_queue_depth_ack ?
                    (ll_queue_depth_drop || (oldDepth >= queue_threshold)) : 1'b1);

  always_comb begin
    newDepth = oldDepth;
    if (isEnq && oldDepth != MaxDepth) newDepth = oldDepth + DW'(1);
    else if (isDeq && oldDepth != '0) newDepth = oldDepth - DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q     <= 1'b0;
      s2Op_q        <= OP_POLL;
      s2Qid_q       <= '0;
      s3Wr_q        <= 1'b0;
      s3Qid_q       <= '0;
      s3Depth_q     <= '0;
      wbValid_q     <= 1'b0;
      wbQid_q       <= '0;
      wbDepth_q     <= '0;
      enqAck_q      <= 1'b0;
      toEmpty_q     <= 1'b0;
      deqAck_q      <= 1'b0;
      fromEmptyp2_q <= 1'b0;
      pollAck_q     <= 1'b0;
      pollDrop_q    <= 1'b0;
      pollDepth_q   <= '0;
      errOvf_q      <= 1'b0;
      errUnf_q      <= 1'b0;
      errFifo_q     <= 1'b0;
    end else begin
      s2Valid_q     <= p1Valid;
      s2Op_q        <= p1Op;
      s2Qid_q       <= p1Qid;
      s3Wr_q        <= isEnq || isDeq;
      s3Qid_q       <= s2Qid_q;
      s3Depth_q     <= newDepth;
      wbValid_q     <= s3Wr_q;
      wbQid_q       <= s3Qid_q;
      wbDepth_q     <= s3Depth_q;
      enqAck_q      <= isEnq;
      toEmpty_q     <= isEnq && (oldDepth == '0);
      deqAck_q      <= isDeq;
      fromEmptyp2_q <= isDeq && (oldDepth >= DW'(2));
      pollAck_q     <= isPoll;
      pollDrop_q    <= pollDrop;
      if (isPoll) pollDepth_q <= oldDepth;
      errOvf_q      <= errOvf_q || (isEnq && oldDepth == MaxDepth);
      errUnf_q      <= errUnf_q || (isDeq && oldDepth == '0);
      errFifo_q     <= errFifo_q || enqOvf || deqOvf || pollOvf;
    end
  end

`ifdef TM_QUEUE_DEPTH_STATS_EN
  logic [31:0]   dropCount_q;
  logic [DW-1:0] peakDepth_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropCount_q <= '0;
      peakDepth_q <= '0;
    end else begin
      if (pollDrop && dropCount_q != '1) dropCount_q <= dropCount_q + 32'd1;
      if (s3Wr_q && s3Depth_q > peakDepth_q) peakDepth_q <= s3Depth_q;
    end
  end

  assign drop_count = dropCount_q;
  assign peak_depth = peakDepth_q;
`endif

  assign depth_enq_ack          = enqAck_q;
  assign depth_enq_to_empty     = toEmpty_q;
  assign depth_deq_ack          = deqAck_q;
  assign depth_deq_from_emptyp2 = fromEmptyp2_q;
  assign poll_ack               = pollAck_q;
  assign poll_drop              = pollDrop_q;
  assign poll_depth             = pollDepth_q;
  assign init_done              = initDone_q;
  assign err_overflow           = errOvf_q;
  assign err_underflow          = errUnf_q;
  assign err_fifo_ovf           = errFifo_q;
endmodule

// File: tb/tb_tm_queue_depth.sv
// tb_tm_queue_depth: directed vector table plus hand-written multi-cycle sequences for tm_queue_depth.
// Statistics outputs are connected and checked only when TM_QUEUE_DEPTH_STATS_EN is defined.
module tb_tm_queue_depth;
  localparam int QN = 4;

  typedef enum logic [1:0] {T_ENQ, T_DEQ, T_POLL} tOp_e;
  typedef struct {
    tOp_e          op;
    logic [QN-1:0] qid;
    logic [QN:0]   thr;
    logic          llDrop;
    logic          expFlag;
    logic [QN:0]   expDepth;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq_req, deq_req, poll_req;
  logic [QN-1:0] enq_qid, deq_qid, poll_qid;
  logic          depth_enq_ack, depth_enq_to_empty, depth_deq_ack, depth_deq_from_emptyp2;
  logic          queue_depth_req;
  logic          llAck = 1'b0;
  logic          llDropIn;
  logic [QN:0]   llThr;
  logic          poll_ack, poll_drop;
  logic [QN:0]   poll_depth;
  logic          init_done, err_overflow, err_underflow, err_fifo_ovf;
`ifdef TM_QUEUE_DEPTH_STATS_EN
  logic [31:0]   drop_count;
  logic [QN:0]   peak_depth;
`endif

  int   total = 0;
  int   bad = 0;
  int   enqAcks;
  vec_t vecs[20];

  tm_queue_depth #(.QID_NBITS(QN), .FIFO_NBITS(2)) dut (
    .clk(clk), .rst(rst),
    .enq_req(enq_req), .enq_qid(enq_qid),
    .deq_req(deq_req), .deq_qid(deq_qid),
    .poll_req(poll_req), .poll_qid(poll_qid),
    .depth_enq_ack(depth_enq_ack), .depth_enq_to_empty(depth_enq_to_empty),
    .depth_deq_ack(depth_deq_ack), .depth_deq_from_emptyp2(depth_deq_from_emptyp2),
    .queue_depth_req(queue_depth_req),
    .ll_queue_depth_ack(llAck), .ll_queue_depth_drop(llDropIn), .queue_threshold(llThr),
    .poll_ack(poll_ack), .poll_drop(poll_drop), .poll_depth(poll_depth),
    .init_done(init_done), .err_overflow(err_overflow), .err_underflow(err_underflow),
`ifdef TM_QUEUE_DEPTH_STATS_EN
    .drop_count(drop_count), .peak_depth(peak_depth),
`endif
    .err_fifo_ovf(err_fifo_ovf));

  always #5 clk = ~clk;

  // Linked-list stage stand-in: answers every threshold query one cycle later.
  always @(posedge clk) llAck <= queue_depth_req;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearStimulus();
    enq_req = 1'b0; deq_req = 1'b0; poll_req = 1'b0;
    enq_qid = '0;   deq_qid = '0;   poll_qid = '0;
  endtask

  task automatic applyStimulus(input tOp_e op, input logic [QN-1:0] q);
    clearStimulus();
    case (op)
      T_ENQ:   begin enq_req = 1'b1;  enq_qid = q;  end
      T_DEQ:   begin deq_req = 1'b1;  deq_qid = q;  end
      default: begin poll_req = 1'b1; poll_qid = q; end
    endcase
  endtask

  // Issue one op at a negedge and check its ack three negedges later, leaving the pipeline idle.
  task automatic runVec(input int idx);
    vec_t v;
    v = vecs[idx];
    llThr = v.thr;
    llDropIn = v.llDrop;
    applyStimulus(v.op, v.qid);
    @(negedge clk);
    clearStimulus();
    @(negedge clk);
    @(negedge clk);
    case (v.op)
      T_ENQ: begin
        checkOutput($sformatf("vec%0d enq_ack", idx), 32'(depth_enq_ack), 1);
        checkOutput($sformatf("vec%0d to_empty", idx), 32'(depth_enq_to_empty), 32'(v.expFlag));
      end
      T_DEQ: begin
        checkOutput($sformatf("vec%0d deq_ack", idx), 32'(depth_deq_ack), 1);
        checkOutput($sformatf("vec%0d from_emptyp2", idx), 32'(depth_deq_from_emptyp2), 32'(v.expFlag));
      end
      default: begin
        checkOutput($sformatf("vec%0d poll_ack", idx), 32'(poll_ack), 1);
        checkOutput($sformatf("vec%0d poll_drop", idx), 32'(poll_drop), 32'(v.expFlag));
        checkOutput($sformatf("vec%0d poll_depth", idx), 32'(poll_depth), 32'(v.expDepth));
      end
    endcase
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{T_POLL, 4'd5,  5'd1,  1'b0, 1'b0, 5'd0};
    vecs[1]  = '{T_POLL, 4'd3,  5'd8,  1'b0, 1'b0, 5'd3};
    vecs[2]  = '{T_POLL, 4'd3,  5'd3,  1'b0, 1'b1, 5'd3};
    vecs[3]  = '{T_POLL, 4'd3,  5'd4,  1'b0, 1'b0, 5'd3};
    vecs[4]  = '{T_POLL, 4'd5,  5'd8,  1'b1, 1'b1, 5'd0};
    vecs[5]  = '{T_DEQ,  4'd9,  5'd0,  1'b0, 1'b0, 5'd0};
    vecs[6]  = '{T_POLL, 4'd9,  5'd1,  1'b0, 1'b0, 5'd0};
    vecs[7]  = '{T_ENQ,  4'd7,  5'd0,  1'b0, 1'b1, 5'd0};
    vecs[8]  = '{T_POLL, 4'd7,  5'd2,  1'b0, 1'b0, 5'd1};
    vecs[9]  = '{T_ENQ,  4'd0,  5'd0,  1'b0, 1'b1, 5'd0};
    vecs[10] = '{T_DEQ,  4'd0,  5'd0,  1'b0, 1'b0, 5'd0};
    vecs[11] = '{T_POLL, 4'd0,  5'd31, 1'b0, 1'b0, 5'd0};
    vecs[12] = '{T_POLL, 4'd1,  5'd17, 1'b0, 1'b0, 5'd16};
    vecs[13] = '{T_ENQ,  4'd1,  5'd0,  1'b0, 1'b0, 5'd0};
    vecs[14] = '{T_POLL, 4'd1,  5'd16, 1'b0, 1'b1, 5'd16};
    vecs[15] = '{T_DEQ,  4'd1,  5'd0,  1'b0, 1'b1, 5'd0};
    vecs[16] = '{T_POLL, 4'd1,  5'd31, 1'b0, 1'b0, 5'd15};
    vecs[17] = '{T_POLL, 4'd12, 5'd31, 1'b0, 1'b0, 5'd4};
    vecs[18] = '{T_POLL, 4'd12, 5'd31, 1'b0, 1'b0, 5'd0};
    vecs[19] = '{T_POLL, 4'd2,  5'd1,  1'b0, 1'b0, 5'd0};

    clearStimulus();
    llThr = '0;
    llDropIn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset init_done", 32'(init_done), 0);
    checkOutput("reset acks", 32'({depth_enq_ack, depth_deq_ack, poll_ack, poll_drop}), 0);
    checkOutput("reset queue_depth_req", 32'(queue_depth_req), 0);
    checkOutput("reset poll_depth", 32'(poll_depth), 0);
    checkOutput("reset errors", 32'({err_overflow, err_underflow, err_fifo_ovf}), 0);

    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("init_done after 15", 32'(init_done), 0);
    @(negedge clk);
    checkOutput("init_done after 16", 32'(init_done), 1);

    for (int k = 0; k < 6; k++) begin
      if (k >= 3) begin
        checkOutput($sformatf("b2b enq%0d ack", k-3), 32'(depth_enq_ack), 1);
        checkOutput($sformatf("b2b enq%0d to_empty", k-3), 32'(depth_enq_to_empty), (k == 3) ? 1 : 0);
      end
      if (k < 3) applyStimulus(T_ENQ, 4'd3);
      else clearStimulus();
      @(negedge clk);
    end

    for (int i = 0; i < 12; i++) runVec(i);
    checkOutput("err_underflow", 32'(err_underflow), 1);

    for (int k = 0; k < 6; k++) begin
      if (k >= 3) begin
        checkOutput($sformatf("b2b deq%0d ack", k-3), 32'(depth_deq_ack), 1);
        checkOutput($sformatf("b2b deq%0d from_emptyp2", k-3), 32'(depth_deq_from_emptyp2), (k == 5) ? 0 : 1);
      end
      if (k < 3) applyStimulus(T_DEQ, 4'd3);
      else clearStimulus();
      @(negedge clk);
    end

    // Queue 7 holds depth 1; the same-cycle trio must look serial in deq, enq, poll order.
    llThr = 5'd2;
    llDropIn = 1'b0;
    enq_req = 1'b1; enq_qid = 4'd7;
    deq_req = 1'b1; deq_qid = 4'd7;
    poll_req = 1'b1; poll_qid = 4'd7;
    @(negedge clk);
    clearStimulus();
    @(negedge clk);
    @(negedge clk);
    checkOutput("trio deq_ack", 32'(depth_deq_ack), 1);
    checkOutput("trio from_emptyp2", 32'(depth_deq_from_emptyp2), 0);
    checkOutput("trio enq_ack early", 32'(depth_enq_ack), 0);
    @(negedge clk);
    checkOutput("trio enq_ack", 32'(depth_enq_ack), 1);
    checkOutput("trio to_empty", 32'(depth_enq_to_empty), 1);
    checkOutput("trio poll_ack early", 32'(poll_ack), 0);
    @(negedge clk);
    checkOutput("trio poll_ack", 32'(poll_ack), 1);
    checkOutput("trio poll_depth", 32'(poll_depth), 1);
    checkOutput("trio poll_drop", 32'(poll_drop), 0);
    @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      applyStimulus(T_ENQ, 4'd1);
      @(negedge clk);
    end
    clearStimulus();
    repeat (4) @(negedge clk);
    checkOutput("err_overflow before", 32'(err_overflow), 0);
    runVec(12);
    runVec(13);
    checkOutput("err_overflow after", 32'(err_overflow), 1);
    for (int i = 14; i < 17; i++) runVec(i);

    checkOutput("err_fifo_ovf before", 32'(err_fifo_ovf), 0);
    enqAcks = 0;
    for (int k = 0; k < 40; k++) begin
      if (depth_enq_ack) enqAcks++;
      clearStimulus();
      if (k < 10) begin deq_req = 1'b1; deq_qid = 4'd9; end
      if (k >= 1 && k <= 6) begin enq_req = 1'b1; enq_qid = 4'd12; end
      @(negedge clk);
    end
    checkOutput("fifo_ovf enq acks", 32'(enqAcks), 4);
    checkOutput("err_fifo_ovf after", 32'(err_fifo_ovf), 1);
    runVec(17);

`ifdef TM_QUEUE_DEPTH_STATS_EN
    checkOutput("drop_count", drop_count, 3);
    checkOutput("peak_depth", 32'(peak_depth), 16);
`endif

    applyStimulus(T_ENQ, 4'd2);
    @(negedge clk);
    clearStimulus();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset enq_ack", 32'(depth_enq_ack), 0);
    @(negedge clk);
    checkOutput("midreset enq_ack late", 32'(depth_enq_ack), 0);
    checkOutput("midreset init_done", 32'(init_done), 0);
    checkOutput("midreset errors", 32'({err_overflow, err_underflow, err_fifo_ovf}), 0);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    checkOutput("reinit init_done", 32'(init_done), 1);
    checkOutput("reinit stray enq_ack", 32'(depth_enq_ack), 0);
    runVec(18);
    runVec(19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tm_queue_depth.md
# tm_queue_depth

Per-queue occupancy tracker for the traffic manager first-level queues. It sits beside the linked-list stage and answers its enqueue and dequeue depth requests with the empty-transition flags that stage needs. It also performs admission polling for the upstream classifier, comparing the current depth against the linked-list stage's dynamic threshold and free-buffer state. One operation is processed per cycle through a 3-stage pipeline over a depth RAM.

## Interface
- QID_NBITS, `FIRST_LVL_QUEUE_ID_NBITS; queue id width; depth RAM has 2^QID_NBITS entries of QID_NBITS+1 bits
- FIFO_NBITS, 2; log2 depth of each input request FIFO (4 entries)

Ports:
- clk  in  1  single clock, all logic rising-edge
- `RESET_SIG  in  1  asynchronous, active-high reset
- enq_req / enq_qid  in  1 / QID_NBITS  enqueue depth request from the linked-list stage
- deq_req / deq_qid  in  1 / QID_NBITS  dequeue depth request from the linked-list stage
- poll_req / poll_qid  in  1 / QID_NBITS  admission poll from upstream
- depth_enq_ack  out  1  enqueue processed
- depth_enq_to_empty  out  1  queue depth was 0 before this enqueue
- depth_deq_ack  out  1  dequeue processed
- depth_deq_from_emptyp2  out  1  depth was >=2 before this dequeue, so the queue stays non-empty
- queue_depth_req  out  1  threshold query to the linked-list stage
- ll_queue_depth_ack  in  1  query answer, valid exactly 1 cycle after queue_depth_req
- ll_queue_depth_drop  in  1  free buffers near exhaustion, valid with ack
- queue_threshold  in  QID_NBITS+1  dynamic per-queue limit, valid with ack
- poll_ack / poll_drop  out  1 / 1  poll result; drop=1 means reject
- poll_depth  out  QID_NBITS+1  depth seen by the poll
- init_done  out  1  depth RAM cleared
- err_overflow / err_underflow / err_fifo_ovf  out  1 each  sticky error flags

## Operation
- States: INIT, RUN. The reset value is INIT.
  - INIT writes 0 to RAM addresses 0..2^QID_NBITS-1, one address per cycle. On the last address the block sets init_done and moves to RUN.
  - Requests are captured into the FIFOs during INIT, but nothing is popped until RUN.
- Three input FIFOs (enq, deq, poll) are order-preserving.
  - A write to a full FIFO drops the request and sets err_fifo_ovf.
  - Upstream guarantees an average aggregate rate of at most 1 request per cycle.
- Arbiter pops at most one FIFO per cycle. Fixed priority: deq > enq > poll.
- Pipeline:
  - P1 registers op and qid, issues the RAM read, and asserts queue_depth_req when op = poll.
  - P2 receives the RAM data and applies the bypass, then computes the new depth and the flags.
  - P3 performs the RAM write for enq and deq and registers the acks.
- Bypass: when P2's qid matches either of the two preceding in-flight writes, P2 uses the youngest matching write data. Results must equal strictly serial execution.
- Enq: new = old+1 and to_empty = (old==0). If old == 2^QID_NBITS, depth is held and err_overflow is set.
- Deq: new = old-1 and from_emptyp2 = (old>=2). If old == 0, depth stays 0, err_underflow is set, and the ack is still returned with the flag at 0.
- Poll: drop = ll_queue_depth_drop | (old >= queue_threshold), both compared unsigned at QID_NBITS+1 bits. Depth is not written.
- Acks for each request type return in the same order as that type's requests.

## Timing
- A request at cycle t with an empty pipeline and no contention is popped at t+1. Its ack or poll_ack is asserted in cycle t+3 for exactly 1 cycle.
- queue_depth_req is asserted in t+1. The ack, threshold and drop inputs are sampled in t+2.
- Sustained throughput is 1 op per cycle, including back-to-back ops on the same qid.
- Reset values: every ack, queue_depth_req, poll_drop, init_done and err_* is 0. poll_depth and the depth flags are 0.
- Reset asserted mid-operation: the FIFOs are flushed, in-flight ops are discarded with no acks, and INIT is re-entered.

## Configuration
- TM_QUEUE_DEPTH_STATS_EN defined:
  - adds a drop_count output (32 bits): increments on each poll with drop=1 and saturates at 2^32-1;
  - adds a peak_depth output (QID_NBITS+1 bits): the maximum depth ever written.
  - Both reset to 0.
- TM_QUEUE_DEPTH_STATS_EN undefined: neither output port nor its logic exists. All other behaviour is identical.

## Test plan
- Reset release: init_done is high after exactly 2^QID_NBITS RUN-less cycles. A poll on qid 5 with threshold 1 then gives poll_depth=0 and poll_drop=0.
- enq qid 3 three times back-to-back:
  - to_empty sequence is 1,0,0;
  - a subsequent poll gives depth 3;
  - deq qid 3 three times gives from_emptyp2 1,1,0.
- Same cycle enq q7, deq q7, poll q7 with depth 1 and threshold 2: deq is acked first (from_emptyp2=0), then enq (to_empty=1), then poll (depth 1, drop 0).
- Poll with ll_queue_depth_drop=1, depth 0, threshold 8 gives poll_drop=1. With the macro defined, drop_count = 1.
- deq on an empty qid 9 gives an ack with flag 0, err_underflow=1, and depth staying 0.
- 6 enq requests in consecutive cycles while deq traffic saturates the arbiter: the 5th write overflows the FIFO, err_fifo_ovf=1, and exactly 4 enq acks are returned.
